// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared data-cache geometry constants and sizing helpers
package ariane_pkg;

  localparam int unsigned DCACHE_NUM_SETS = 256;
  localparam int unsigned DCACHE_NUM_WAYS = 4;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_flush_way_sel.sv
// rtl/dcache_flush_way_sel.sv - lowest-set-bit way picker for the flush write-back mask
module dcache_flush_way_sel
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_WAYS = DCACHE_NUM_WAYS
) (
  input  logic [NUM_WAYS-1:0]            mask_i,
  output logic [idx_width(NUM_WAYS)-1:0] idx_o,
  output logic                           valid_o
);

  localparam int unsigned WAY_W = idx_width(NUM_WAYS);

  // Scan high to low so the last hit wins, leaving the lowest set way.
  always_comb begin
    idx_o   = '0;
    valid_o = |mask_i;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = WAY_W'(i);
    end
  end

endmodule

// File: rtl/dcache_flush_unit.sv
// rtl/dcache_flush_unit.sv - walks every D$ set, writes back dirty ways, invalidates, acks
module dcache_flush_unit
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_SETS = DCACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS = DCACHE_NUM_WAYS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  output logic                           flush_ack_o,
  output logic                           busy_o,
  output logic                           tag_req_o,
  output logic [$clog2(NUM_SETS)-1:0]    tag_index_o,
  input  logic                           tag_gnt_i,
  input  logic                           tag_rvalid_i,
  input  logic [NUM_WAYS-1:0]            valid_i,
  input  logic [NUM_WAYS-1:0]            dirty_i,
  output logic                           wb_req_o,
  output logic [idx_width(NUM_WAYS)-1:0] wb_way_o,
  input  logic                           wb_gnt_i,
  input  logic                           wb_done_i,
  output logic                           inv_we_o
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = idx_width(NUM_WAYS);
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] READ_TAG   = 3'd1;
  localparam logic [2:0] WAIT_TAG   = 3'd2;
  localparam logic [2:0] WB_REQ     = 3'd3;
  localparam logic [2:0] WB_WAIT    = 3'd4;
  localparam logic [2:0] INVALIDATE = 3'd5;
  localparam logic [2:0] ACK        = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [NUM_WAYS-1:0] mask_q, mask_d;
  logic                ack_q, ack_d;

  logic [WAY_W-1:0]    way_idx;
  logic                way_vld;
  logic [NUM_WAYS-1:0] way_onehot;
  logic [NUM_WAYS-1:0] capture_mask;
  logic [NUM_WAYS-1:0] remain_mask;

  dcache_flush_way_sel #(
    .NUM_WAYS (NUM_WAYS)
  ) i_way_sel (
    .mask_i  (mask_q),
    .idx_o   (way_idx),
    .valid_o (way_vld)
  );

  assign way_onehot   = NUM_WAYS'(1) << way_idx;
  assign capture_mask = valid_i & dirty_i;
  assign remain_mask  = mask_q & ~way_onehot;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    mask_d  = mask_q;
    // Remembers that ack fired so a still-high flush_i cannot retrigger.
    ack_d   = (state_q == ACK);
    case (state_q)
      IDLE: begin
        if (flush_i && !ack_q) begin
          state_d = READ_TAG;
          index_d = '0;
        end
      end
      READ_TAG: begin
        if (tag_gnt_i) state_d = WAIT_TAG;
      end
      WAIT_TAG: begin
        if (tag_rvalid_i) begin
          mask_d  = capture_mask;
          state_d = (|capture_mask) ? WB_REQ : INVALIDATE;
        end
      end
      WB_REQ: begin
        if (wb_gnt_i) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        if (wb_done_i) begin
          mask_d  = remain_mask;
          state_d = (|remain_mask) ? WB_REQ : INVALIDATE;
        end
      end
      INVALIDATE: begin
        if (index_q == LAST_SET) begin
          state_d = ACK;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = READ_TAG;
        end
      end
      ACK: begin
        state_d = IDLE;
        index_d = '0;
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      index_q <= '0;
      mask_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign tag_req_o   = (state_q == READ_TAG);
  assign tag_index_o = index_q;
  assign wb_req_o    = (state_q == WB_REQ) && way_vld;
  assign wb_way_o    = way_idx;
  assign inv_we_o    = (state_q == INVALIDATE);
  assign flush_ack_o = (state_q == ACK);

endmodule

// File: tb/tb_dcache_flush_unit.sv
// tb/tb_dcache_flush_unit.sv - directed bench with an event-queue model of the flush walk
module tb_dcache_flush_unit;

  localparam int NS = 4;
  localparam int NW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          flush_ack_o;
  logic          busy_o;
  logic          tag_req_o;
  logic [1:0]    tag_index_o;
  logic          tag_gnt_i;
  logic          tag_rvalid_i;
  logic [NW-1:0] valid_i;
  logic [NW-1:0] dirty_i;
  logic          wb_req_o;
  logic [1:0]    wb_way_o;
  logic          wb_gnt_i;
  logic          wb_done_i;
  logic          inv_we_o;

  always #5 clk_i = ~clk_i;

  dcache_flush_unit #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .flush_ack_o  (flush_ack_o),
    .busy_o       (busy_o),
    .tag_req_o    (tag_req_o),
    .tag_index_o  (tag_index_o),
    .tag_gnt_i    (tag_gnt_i),
    .tag_rvalid_i (tag_rvalid_i),
    .valid_i      (valid_i),
    .dirty_i      (dirty_i),
    .wb_req_o     (wb_req_o),
    .wb_way_o     (wb_way_o),
    .wb_gnt_i     (wb_gnt_i),
    .wb_done_i    (wb_done_i),
    .inv_we_o     (inv_we_o)
  );

  typedef struct { int kind; int idx; int way; } ev_t;  // kind 0=wb 1=inv 2=ack

  int checks = 0;
  int failures = 0;
  ev_t exp_q[$];
  int  wb_ways_seen[$];
  logic [NW-1:0] mem_v [NS];
  logic [NW-1:0] mem_d [NS];
  int cyc = 0, first_busy = -1, ack_cyc = -1, first_req_idx = -1;
  int stall_cnt = 0, stall_seen = 0, inv_cnt = 0, ack_cnt = 0;
  int wb_cnt = 0, gidx = 0;
  bit wb_outstanding = 0, spur_done_arm = 0, spur_rv_arm = 0;
  logic prev_tag_req = 0, prev_wb_req = 0;
  int prev_tag_idx = 0, prev_wb_way = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected flush: every set in order, its valid&dirty ways ascending, then its invalidate; ack last.
  task automatic build_expect();
    ev_t e;
    exp_q.delete();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        if (mem_v[s][w] && mem_d[s][w]) begin
          e.kind = 0; e.idx = s; e.way = w; exp_q.push_back(e);
        end
      end
      e.kind = 1; e.idx = s; e.way = 0; exp_q.push_back(e);
    end
    e.kind = 2; e.idx = 0; e.way = 0; exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int idx, input int way);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual=kind%0d/idx%0d expected=no_event", kind, idx);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_index", idx, e.idx);
      if (kind == 0) check("event_wb_way", way, e.way);
    end
  endtask

  // Monitor + memory responders, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rst_ni) begin
        if (prev_tag_req && !tag_gnt_i) begin
          check("tag_req_held", int'(tag_req_o), 1);
          check("tag_index_held", int'(tag_index_o), prev_tag_idx);
        end
        if (prev_wb_req && !wb_gnt_i) begin
          check("wb_req_held", int'(wb_req_o), 1);
          check("wb_way_held", int'(wb_way_o), prev_wb_way);
        end
        if (busy_o && first_busy < 0) first_busy = cyc;
        if (tag_req_o && first_req_idx < 0) first_req_idx = int'(tag_index_o);
        if (tag_req_o || wb_req_o || inv_we_o || flush_ack_o) check("busy_when_active", int'(busy_o), 1);
        if (wb_req_o) check("single_wb_outstanding", int'(wb_outstanding), 0);
        if (inv_we_o) begin
          observe(1, int'(tag_index_o), 0);
          mem_v[tag_index_o] = '0;
          mem_d[tag_index_o] = '0;
          inv_cnt++;
        end
        if (flush_ack_o) begin
          observe(2, 0, 0);
          ack_cnt++;
          ack_cyc = cyc;
        end

        tag_rvalid_i = tag_gnt_i;
        if (tag_gnt_i) begin
          valid_i = mem_v[gidx];
          dirty_i = mem_d[gidx];
        end else begin
          valid_i = 4'($urandom);
          dirty_i = 4'($urandom);
        end
        if (spur_rv_arm && wb_outstanding) begin
          tag_rvalid_i = 1'b1;
          valid_i = 4'hF;
          dirty_i = 4'hF;
          spur_rv_arm = 0;
        end

        wb_done_i = 1'b0;
        if (wb_cnt > 0) begin
          wb_cnt--;
          if (wb_cnt == 0) begin
            wb_done_i = 1'b1;
            wb_outstanding = 0;
          end
        end
        if (spur_done_arm && tag_req_o && tag_index_o == 2'd1) begin
          wb_done_i = 1'b1;
          spur_done_arm = 0;
        end
        if (wb_gnt_i) begin
          wb_cnt = 2;
          wb_outstanding = 1;
        end

        tag_gnt_i = 1'b0;
        if (tag_req_o) begin
          if (stall_cnt > 0) begin
            stall_cnt--;
            stall_seen++;
          end else begin
            tag_gnt_i = 1'b1;
            gidx = int'(tag_index_o);
          end
        end
        wb_gnt_i = wb_req_o;
        if (wb_req_o) begin
          observe(0, int'(tag_index_o), int'(wb_way_o));
          wb_ways_seen.push_back(int'(wb_way_o));
        end
      end else begin
        tag_gnt_i = 0; tag_rvalid_i = 0; wb_gnt_i = 0; wb_done_i = 0;
        valid_i = '0; dirty_i = '0;
        wb_cnt = 0; wb_outstanding = 0;
      end
      prev_tag_req = tag_req_o;
      prev_tag_idx = int'(tag_index_o);
      prev_wb_req  = wb_req_o;
      prev_wb_way  = int'(wb_way_o);
    end
  end

  task automatic start_flush();
    build_expect();
    first_busy = -1;
    first_req_idx = -1;
    wb_ways_seen.delete();
    @(posedge clk_i); #2;
    flush_i = 1'b1;
  endtask

  task automatic wait_ack(input int limit);
    int n = 0;
    int a0 = ack_cnt;
    while (ack_cnt == a0 && n < limit) begin
      @(posedge clk_i);
      n++;
    end
    if (ack_cnt == a0) check("ack_timeout", 0, 1);
    #2;
  endtask

  initial begin
    int bc;
    int n;
    rst_ni = 0; flush_i = 0;
    tag_gnt_i = 0; tag_rvalid_i = 0; wb_gnt_i = 0; wb_done_i = 0;
    valid_i = '0; dirty_i = '0;
    for (int s = 0; s < NS; s++) begin mem_v[s] = '0; mem_d[s] = '0; end
    repeat (3) @(posedge clk_i);
    #2;
    check("reset_busy", int'(busy_o), 0);
    check("reset_tag_req", int'(tag_req_o), 0);
    check("reset_tag_index", int'(tag_index_o), 0);
    check("reset_wb_req", int'(wb_req_o), 0);
    check("reset_wb_way", int'(wb_way_o), 0);
    check("reset_inv_we", int'(inv_we_o), 0);
    check("reset_ack", int'(flush_ack_o), 0);
    rst_ni = 1;

    // Clean cache (some valid-but-clean lines), zero-wait memories.
    mem_v[0] = 4'b0101; mem_v[3] = 4'b1111;
    inv_cnt = 0;
    start_flush();
    wait_ack(200);
    check("clean_latency", ack_cyc - first_busy + 1, 13);
    check("clean_inv_count", inv_cnt, 4);
    check("clean_no_wb", wb_ways_seen.size(), 0);
    check("clean_queue_drained", exp_q.size(), 0);
    // flush_i still high for one IDLE cycle after ack must not retrigger.
    @(posedge clk_i); #2;
    flush_i = 0;
    bc = 0;
    repeat (6) begin @(posedge clk_i); #2; bc += int'(busy_o); end
    check("no_retrigger_after_ack", bc, 0);

    // Set 2 partially dirty: ways 1 and 3 only.
    mem_v[2] = 4'b1111; mem_d[2] = 4'b1010;
    start_flush();
    wait_ack(300);
    flush_i = 0;
    check("dirty_wb_count", wb_ways_seen.size(), 2);
    if (wb_ways_seen.size() == 2) begin
      check("dirty_wb_first", wb_ways_seen[0], 1);
      check("dirty_wb_second", wb_ways_seen[1], 3);
    end
    check("dirty_queue_drained", exp_q.size(), 0);

    // Grant withheld five cycles on set 0; flush_i dropped mid-flush.
    stall_cnt = 5; stall_seen = 0;
    start_flush();
    repeat (3) @(posedge clk_i);
    #2;
    flush_i = 0;
    wait_ack(300);
    check("stall_cycles", stall_seen, 5);
    check("stall_queue_drained", exp_q.size(), 0);

    // Reset during WB_WAIT of set 1, then restart.
    mem_v[1] = 4'b1111; mem_d[1] = 4'b0110;
    start_flush();
    n = 0;
    while (!(wb_outstanding && tag_index_o == 2'd1) && n < 200) begin
      @(posedge clk_i); #2; n++;
    end
    check("reached_wb_wait_set1", int'(wb_outstanding && tag_index_o == 2'd1), 1);
    n = ack_cnt;
    rst_ni = 0;
    flush_i = 0;
    #1;
    check("abort_busy", int'(busy_o), 0);
    check("abort_tag_req", int'(tag_req_o), 0);
    check("abort_tag_index", int'(tag_index_o), 0);
    check("abort_wb_req", int'(wb_req_o), 0);
    check("abort_wb_way", int'(wb_way_o), 0);
    check("abort_inv_we", int'(inv_we_o), 0);
    check("abort_ack", int'(flush_ack_o), 0);
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #2;
    rst_ni = 1;
    bc = 0;
    repeat (8) begin @(posedge clk_i); #2; bc += int'(busy_o); end
    check("idle_after_abort", bc, 0);
    check("no_ack_for_aborted", ack_cnt, n);
    start_flush();
    wait_ack(300);
    flush_i = 0;
    check("restart_first_index", first_req_idx, 0);
    check("restart_wb_count", wb_ways_seen.size(), 2);
    check("restart_queue_drained", exp_q.size(), 0);

    // Spurious wb_done in READ_TAG of set 1 and spurious rvalid in WB_WAIT of set 3.
    mem_v[3] = 4'b1111; mem_d[3] = 4'b1001;
    spur_done_arm = 1; spur_rv_arm = 1;
    start_flush();
    wait_ack(300);
    flush_i = 0;
    check("spur_done_fired", int'(spur_done_arm), 0);
    check("spur_rvalid_fired", int'(spur_rv_arm), 0);
    check("spur_wb_count", wb_ways_seen.size(), 2);
    if (wb_ways_seen.size() == 2) begin
      check("spur_wb_first", wb_ways_seen[0], 0);
      check("spur_wb_second", wb_ways_seen[1], 3);
    end
    check("spur_queue_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_flush_unit.md
DCACHE_FLUSH_UNIT -- requirements
Module: dcache_flush_unit

Interface
- REQ-001 SHALL provide parameter NUM_SETS, default 256, number of D$ sets (power of 2, >=2).
- REQ-002 SHALL provide parameter NUM_WAYS, default 4, number of D$ ways (power of 2, >=1).
- REQ-003 clk_i  input  1  clock; all state updates on rising edge.
- REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
- REQ-005 flush_i  input  1  flush request from flush controller; level, held until flush_ack_o.
- REQ-006 flush_ack_o  output  1  single-cycle pulse: whole cache written back and invalidated.
- REQ-007 busy_o  output  1  high in every state except IDLE.
- REQ-008 tag_req_o  output  1  tag/status array read request.
- REQ-009 tag_index_o  output  log2(NUM_SETS)  set index for tag read and invalidate.
- REQ-010 tag_gnt_i  input  1  tag array accepts tag_req_o this cycle.
- REQ-011 tag_rvalid_i  input  1  status data valid; arrives >=1 cycle after grant.
- REQ-012 valid_i  input  NUM_WAYS  per-way valid bits of read set.
- REQ-013 dirty_i  input  NUM_WAYS  per-way dirty bits of read set.
- REQ-014 wb_req_o  output  1  write-back request for line (tag_index_o, wb_way_o).
- REQ-015 wb_way_o  output  log2(NUM_WAYS) (min 1)  way to write back.
- REQ-016 wb_gnt_i  input  1  write-back request accepted.
- REQ-017 wb_done_i  input  1  write-back of accepted line complete.
- REQ-018 inv_we_o  output  1  one-cycle write clearing valid/dirty of all ways at tag_index_o.

Function
- REQ-019 FSM states SHALL be IDLE, READ_TAG, WAIT_TAG, WB_REQ, WB_WAIT, INVALIDATE, ACK.
- REQ-020 IDLE: flush_i=1 and flush_ack_o not asserted previous cycle -> READ_TAG, index=0; else stay.
- REQ-021 READ_TAG: tag_req_o=1; tag_gnt_i=1 -> WAIT_TAG; request and index held stable until grant.
- REQ-022 WAIT_TAG: on tag_rvalid_i capture mask = valid_i & dirty_i; mask!=0 -> WB_REQ, else -> INVALIDATE.
- REQ-023 WB_REQ: wb_req_o=1, wb_way_o = lowest set bit of mask; held stable until wb_gnt_i; on grant -> WB_WAIT.
- REQ-024 WB_WAIT: on wb_done_i clear serviced bit; remaining mask!=0 -> WB_REQ, else -> INVALIDATE.
- REQ-025 INVALIDATE: inv_we_o=1 exactly one cycle; index==NUM_SETS-1 -> ACK, else index+1 -> READ_TAG.
- REQ-026 ACK: flush_ack_o=1 one cycle -> IDLE.
- REQ-027 Index counter SHALL never wrap within one flush; last set processed exactly once.
- REQ-028 Dirty ways SHALL be written back in ascending way order; at most one write-back outstanding.
- REQ-029 wb_done_i or tag_rvalid_i outside WB_WAIT/WAIT_TAG SHALL be ignored.
- REQ-030 flush_i deassertion mid-flush SHALL be ignored; flush completes and acks.
- REQ-031 Set with no valid&dirty ways SHALL take exactly 3 cycles plus grant/rvalid wait (READ_TAG, WAIT_TAG, INVALIDATE).
- REQ-032 Minimum flush latency, zero-wait memories, clean cache: 3*NUM_SETS+1 cycles from leaving IDLE to ack.
- REQ-033 Valid-but-clean lines SHALL NOT be written back; only invalidated.

Reset
- REQ-034 rst_ni low SHALL force IDLE, index=0, mask=0, all outputs 0, asynchronously, including mid-flush.
- REQ-035 After reset mid-flush no ack SHALL be produced for aborted flush.

Structure
- REQ-036 DCACHE_NUM_SETS and DCACHE_NUM_WAYS constants SHALL live in ariane_pkg; FSM state enum local to module.
- REQ-037 Lowest-set-bit way selection SHALL be one sub-module, dcache_flush_way_sel (mask in, index + valid out).

Verification (NUM_SETS=4, NUM_WAYS=4)
- REQ-038 Clean cache, all grants immediate, rvalid next cycle -> 4 inv_we_o pulses indices 0..3, no wb_req_o, ack at cycle 13.
- REQ-039 Set 2 valid=4'b1111 dirty=4'b1010 -> wb_way_o 1 then 3, then inv_we_o at index 2; way 0/2 not written back.
- REQ-040 tag_gnt_i low 5 cycles on set 0 -> tag_req_o and tag_index_o=0 held stable 5 cycles, no skip.
- REQ-041 rst_ni low during WB_WAIT of set 1 -> all outputs 0 immediately, IDLE; no flush_ack_o; new flush_i restarts at index 0.
- REQ-042 flush_i held high 1 cycle after ack -> no second flush starts; flush_i low then high -> new flush.
- REQ-043 Spurious wb_done_i during READ_TAG -> ignored, write-back sequence of later dirty set unaffected.
